// File: rtl/fpdiv_pkg.sv
// Shared types, exception codes and width helpers for the parametrised FP divider.
package fpdiv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StDivide,
    StNorm,
    StRound
  } fpdiv_state_e;

  localparam logic [1:0] ExcNone      = 2'b00;
  localparam logic [1:0] ExcUnderflow = 2'b01;
  localparam logic [1:0] ExcOverflow  = 2'b10;
  localparam logic [1:0] ExcInvalid   = 2'b11;

  // Total word width: sign + exponent + stored fraction.
  function automatic int unsigned fp_width(int unsigned exp_w, int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  // Exponent bias 2^(exp_w-1)-1.
  function automatic int unsigned fp_bias(int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] fp_qnan(int unsigned exp_w, int unsigned man_w);
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fpdiv_lzc.sv
// Combinational leading-zero counter; an all-zero input returns W.
module fpdiv_lzc #(
  parameter int unsigned W = 24
) (
  input  logic [W-1:0]           i_val,
  output logic [$clog2(W+1)-1:0] o_cnt
);

  localparam int unsigned CW = $clog2(W + 1);

  // Scan from LSB upward so the highest set bit wins.
  always_comb begin
    o_cnt = CW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (i_val[i]) o_cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fpdiv_param.sv
// Iterative IEEE-754 divider: unpack/classify, restoring divide, normalise, RNE round.
module fpdiv_param
  import fpdiv_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic [EXP_W+MAN_W:0]   InputA,
  input  logic [EXP_W+MAN_W:0]   InputB,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [EXP_W+MAN_W:0]   AbyB,
  output logic [1:0]             EXCEPTION
);

  localparam int unsigned W    = fp_width(EXP_W, MAN_W);
  localparam int unsigned MW   = MAN_W + 1;          // significand with hidden bit
  localparam int unsigned LZW  = $clog2(MW + 1);
  localparam int unsigned QW   = MAN_W + 3;          // quotient bits
  localparam int unsigned RW   = MAN_W + 2;          // remainder bits
  localparam int unsigned EW   = EXP_W + 2;          // signed working exponent
  localparam int unsigned CW   = $clog2(QW);
  localparam int unsigned BIAS = fp_bias(EXP_W);
  localparam logic [EW-1:0] ExpMax = EW'((1 << EXP_W) - 1);

  fpdiv_state_e r_state, w_state_d;

  logic [W-1:0]  r_a, r_b, r_res;
  logic [1:0]    r_exc;
  logic          r_done, r_sign;
  logic [MW-1:0] r_mb, r_sig;
  logic [RW-1:0] r_rem;
  logic [QW-1:0] r_quo;
  logic [CW-1:0] r_cnt;
  logic [EW-1:0] r_exp;
  logic          r_g, r_s;

  // ---------------- unpack / classify ----------------
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_emax, w_b_emax, w_a_ez, w_b_ez;
  logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic [MW-1:0]    w_ma, w_mb, w_ma_n, w_mb_n;
  logic [LZW-1:0]   w_lza, w_lzb;
  logic [EW-1:0]    w_ea_eff, w_eb_eff, w_e_unp;
  logic             w_sign;
  logic [W-1:0]     w_qnan, w_inf, w_zero;

  assign w_ea     = r_a[MAN_W +: EXP_W];
  assign w_eb     = r_b[MAN_W +: EXP_W];
  assign w_fa     = r_a[MAN_W-1:0];
  assign w_fb     = r_b[MAN_W-1:0];
  assign w_a_emax = &w_ea;
  assign w_b_emax = &w_eb;
  assign w_a_ez   = ~|w_ea;
  assign w_b_ez   = ~|w_eb;
  assign w_nan_a  = w_a_emax & (|w_fa);
  assign w_nan_b  = w_b_emax & (|w_fb);
  assign w_inf_a  = w_a_emax & ~(|w_fa);
  assign w_inf_b  = w_b_emax & ~(|w_fb);
  assign w_zero_a = w_a_ez & ~(|w_fa);
  assign w_zero_b = w_b_ez & ~(|w_fb);
  assign w_sign   = r_a[W-1] ^ r_b[W-1];

  assign w_ma = {~w_a_ez, w_fa};
  assign w_mb = {~w_b_ez, w_fb};

  fpdiv_lzc #(.W(MW)) u_lzc_a (.i_val(w_ma), .o_cnt(w_lza));
  fpdiv_lzc #(.W(MW)) u_lzc_b (.i_val(w_mb), .o_cnt(w_lzb));

  assign w_ma_n   = w_ma << w_lza;
  assign w_mb_n   = w_mb << w_lzb;
  // Subnormals behave as exponent 1 before the leading-zero correction.
  assign w_ea_eff = w_a_ez ? EW'(1) : EW'(w_ea);
  assign w_eb_eff = w_b_ez ? EW'(1) : EW'(w_eb);
  assign w_e_unp  = w_ea_eff - w_eb_eff - EW'(w_lza) + EW'(w_lzb) + EW'(BIAS);

  assign w_qnan = W'(fp_qnan(EXP_W, MAN_W));
  assign w_inf  = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign w_zero = {w_sign, {(W-1){1'b0}}};

  logic         w_special;
  logic [W-1:0] w_sp_res;
  logic [1:0]   w_sp_exc;

  // Special-operand fast path; priority order matters (inf/0 yields exact inf).
  always_comb begin
    w_special = 1'b1;
    w_sp_res  = '0;
    w_sp_exc  = ExcNone;
    if (w_nan_a || w_nan_b || (w_zero_a && w_zero_b) || (w_inf_a && w_inf_b)) begin
      w_sp_res = w_qnan;
      w_sp_exc = ExcInvalid;
    end else if (w_inf_a) begin
      w_sp_res = w_inf;
    end else if (w_zero_b) begin
      w_sp_res = w_inf;
      w_sp_exc = ExcOverflow;
    end else if (w_inf_b || w_zero_a) begin
      w_sp_res = w_zero;
    end else begin
      w_special = 1'b0;
    end
  end

  // ---------------- restoring divide step ----------------
  logic          w_ge;
  logic [RW-1:0] w_rem_sub, w_rem_nx;
  logic [QW-1:0] w_quo_nx;

  assign w_ge      = (r_rem >= RW'(r_mb));
  assign w_rem_sub = w_ge ? (r_rem - RW'(r_mb)) : r_rem;
  assign w_rem_nx  = w_rem_sub << 1;
  assign w_quo_nx  = {r_quo[QW-2:0], w_ge};

  // ---------------- normalise ----------------
  logic [MW-1:0] w_n_sig;
  logic          w_n_g, w_n_s;
  logic [EW-1:0] w_n_exp, w_sub_ome, w_sub_sh;
  logic [RW-1:0] w_sub_x, w_sub_shx, w_sub_mask;

  // Align the quotient, then denormalise when the exponent has run out.
  always_comb begin
    if (r_quo[QW-1]) begin
      w_n_sig = r_quo[QW-1:2];
      w_n_g   = r_quo[1];
      w_n_s   = r_quo[0] | (|r_rem);
      w_n_exp = r_exp;
    end else begin
      w_n_sig = r_quo[QW-2:1];
      w_n_g   = r_quo[0];
      w_n_s   = |r_rem;
      w_n_exp = r_exp - EW'(1);
    end
    w_sub_ome  = EW'(1) - w_n_exp;
    w_sub_sh   = ($signed(w_sub_ome) > $signed(EW'(RW))) ? EW'(RW) : w_sub_ome;
    w_sub_x    = {w_n_sig, w_n_g};
    w_sub_shx  = w_sub_x >> w_sub_sh;
    w_sub_mask = ~({RW{1'b1}} << w_sub_sh);
    if ($signed(w_n_exp) <= $signed(EW'(0))) begin
      w_n_sig = w_sub_shx[RW-1:1];
      w_n_g   = w_sub_shx[0];
      w_n_s   = w_n_s | (|(w_sub_x & w_sub_mask));
      w_n_exp = '0;
    end
  end

  // ---------------- round ----------------
  logic          w_r_inc, w_r_inexact, w_r_ovf;
  logic [RW-1:0] w_r_sum;
  logic [EW-1:0] w_r_exp;
  logic [MAN_W-1:0] w_r_frac;
  logic [W-1:0]  w_r_res;
  logic [1:0]    w_r_exc;

  // RNE increment; a carry either bumps the exponent or promotes a subnormal.
  always_comb begin
    w_r_inc     = r_g & (r_s | r_sig[0]);
    w_r_inexact = r_g | r_s;
    w_r_sum     = {1'b0, r_sig} + RW'(w_r_inc);
    w_r_exp     = r_exp;
    w_r_frac    = w_r_sum[MAN_W-1:0];
    if (r_exp == '0) begin
      w_r_exp = EW'(w_r_sum[MAN_W]);
    end else if (w_r_sum[MAN_W+1]) begin
      w_r_exp  = r_exp + EW'(1);
      w_r_frac = w_r_sum[MAN_W:1];
    end
    w_r_ovf = $signed(w_r_exp) >= $signed(ExpMax);
    w_r_res = {r_sign, w_r_exp[EXP_W-1:0], w_r_frac};
    w_r_exc = ExcNone;
    if (w_r_ovf) begin
      w_r_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_r_exc = ExcOverflow;
    end else if ((w_r_exp == '0) && w_r_inexact) begin
      w_r_exc = ExcUnderflow;
    end
  end

  // ---------------- FSM ----------------
  // State register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  // Next-state decode.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (START) w_state_d = StUnpack;
      StUnpack: w_state_d = w_special ? StIdle : StDivide;
      StDivide: if (r_cnt == CW'(QW - 1)) w_state_d = StNorm;
      StNorm:   w_state_d = StRound;
      StRound:  w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Datapath registers, advanced per state.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_exc  <= ExcNone;
      r_done <= 1'b0;
      r_sign <= 1'b0;
      r_mb   <= '0;
      r_sig  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_exp  <= '0;
      r_g    <= 1'b0;
      r_s    <= 1'b0;
    end else begin
      r_done <= (r_state == StRound) || ((r_state == StUnpack) && w_special);
      case (r_state)
        StIdle: begin
          if (START) begin
            r_a <= InputA;
            r_b <= InputB;
          end
        end
        StUnpack: begin
          r_sign <= w_sign;
          if (w_special) begin
            r_res <= w_sp_res;
            r_exc <= w_sp_exc;
          end else begin
            r_mb  <= w_mb_n;
            r_rem <= RW'(w_ma_n);
            r_quo <= '0;
            r_cnt <= '0;
            r_exp <= w_e_unp;
          end
        end
        StDivide: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt + CW'(1);
        end
        StNorm: begin
          r_sig <= w_n_sig;
          r_g   <= w_n_g;
          r_s   <= w_n_s;
          r_exp <= w_n_exp;
        end
        StRound: begin
          r_res <= w_r_res;
          r_exc <= w_r_exc;
        end
        default: ;
      endcase
    end
  end

  assign BUSY      = (r_state != StIdle);
  assign DONE      = r_done;
  assign AbyB      = r_res;
  assign EXCEPTION = r_exc;

endmodule

// File: tb/tb_fpdiv_param.sv
// Scoreboard bench for binary32 and binary16 instances of fpdiv_param.
module tb_fpdiv_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start32 = 1'b0, start16 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, q32o;
  logic [15:0] a16 = '0, b16 = '0, q16o;
  logic        busy32, done32, busy16, done16;
  logic [1:0]  exc32, exc16;

  int total = 0, bad = 0, cyc = 0, n_done32 = 0, n_done16 = 0;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  exc;
    int          lat;
    int          t_acc;
  } exp_t;

  exp_t sb32[$];
  exp_t sb16[$];

  fpdiv_param #(.EXP_W(8), .MAN_W(23)) dut32 (
    .CLOCK(clk), .RESET_N(rst_n), .START(start32), .InputA(a32), .InputB(b32),
    .BUSY(busy32), .DONE(done32), .AbyB(q32o), .EXCEPTION(exc32)
  );

  fpdiv_param #(.EXP_W(5), .MAN_W(10)) dut16 (
    .CLOCK(clk), .RESET_N(rst_n), .START(start16), .InputA(a16), .InputB(b16),
    .BUSY(busy16), .DONE(done16), .AbyB(q16o), .EXCEPTION(exc16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Latency is counted in clock edges from the accepting edge to the edge raising DONE.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] res,
                         input logic [1:0] exc, input int lat, input bit push,
                         output bit was_done);
    int n = 0;
    while (busy32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy32) begin
      total++;
      bad++;
      $display("FAIL issue32_timeout: got busy expected idle");
    end
    was_done = done32;
    start32 = 1'b1;
    a32 = a;
    b32 = b;
    if (push) sb32.push_back('{res, exc, lat, cyc + 1});
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                         input logic [1:0] exc, input int lat);
    int n = 0;
    while (busy16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy16) begin
      total++;
      bad++;
      $display("FAIL issue16_timeout: got busy expected idle");
    end
    start16 = 1'b1;
    a16 = a;
    b16 = b;
    sb16.push_back('{{16'h0, res}, exc, lat, cyc + 1});
    @(negedge clk);
    start16 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb32.size() != 0 || sb16.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb32.size() != 0 || sb16.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb32.size() + sb16.size());
      sb32.delete();
      sb16.delete();
    end
  endtask

  // binary32 monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done32) begin
      n_done32++;
      if (sb32.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done32: got DONE with 0x%0h expected no DONE", q32o);
      end else begin
        e = sb32.pop_front();
        chk("res32", q32o, e.res);
        chk("exc32", 32'(exc32), 32'(e.exc));
        if (e.lat >= 0) chk("lat32", 32'(cyc - e.t_acc), 32'(e.lat));
      end
    end
  end

  // binary16 monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done16) begin
      n_done16++;
      if (sb16.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done16: got DONE with 0x%0h expected no DONE", q16o);
      end else begin
        e = sb16.pop_front();
        chk("res16", 32'(q16o), e.res);
        chk("exc16", 32'(exc16), 32'(e.exc));
        if (e.lat >= 0) chk("lat16", 32'(cyc - e.t_acc), 32'(e.lat));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wd;
    int nd;
    repeat (3) @(negedge clk);
    chk("rst_res", q32o, 32'h0);
    chk("rst_exc", 32'(exc32), 32'h0);
    chk("rst_done", 32'(done32), 32'h0);
    chk("rst_busy", 32'(busy32), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Finite path, 29 edges for binary32.
    issue32(32'h3FBC0000, 32'h3FA00000, 32'h3F966666, 2'b00, 29, 1'b1, wd);
    issue32(32'h40A00000, 32'h40000000, 32'h40200000, 2'b00, 29, 1'b1, wd);
    chk("b2b_accept_in_done", 32'(wd), 32'h1);
    issue32(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 2'b00, 29, 1'b1, wd);
    issue32(32'hC0A00000, 32'h40000000, 32'hC0200000, 2'b00, 29, 1'b1, wd);
    issue32(32'h003FFFFF, 32'h40800000, 32'h00100000, 2'b01, 29, 1'b1, wd);
    issue32(32'h00000001, 32'h7F7FFFFF, 32'h00000000, 2'b01, 29, 1'b1, wd);
    issue32(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 2'b10, 29, 1'b1, wd);
    // Special path: result registered at the end of UNPACK.
    issue32(32'h40A00000, 32'h00000000, 32'h7F800000, 2'b10, 1, 1'b1, wd);
    issue32(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2'b11, 1, 1'b1, wd);
    issue32(32'h00000000, 32'h00000000, 32'h7FC00000, 2'b11, 1, 1'b1, wd);
    issue32(32'hFF800000, 32'h3F800000, 32'hFF800000, 2'b00, 1, 1'b1, wd);
    issue32(32'h3F800000, 32'h7F800000, 32'h00000000, 2'b00, 1, 1'b1, wd);
    issue32(32'h80000000, 32'h40000000, 32'h80000000, 2'b00, 1, 1'b1, wd);
    drain();

    // binary16 instance, 16 edges on the finite path.
    issue16(16'h3C00, 16'h4200, 16'h3555, 2'b00, 16);
    issue16(16'h4500, 16'h4000, 16'h4100, 2'b00, 16);
    issue16(16'h3C00, 16'h0000, 16'h7C00, 2'b10, 1);
    drain();

    // START and operand changes while busy must be ignored.
    issue32(32'h40A00000, 32'h40000000, 32'h40200000, 2'b00, 29, 1'b1, wd);
    for (int i = 0; i < 3; i++) begin
      start32 = 1'b1;
      a32 = 32'h3F800000 + 32'(i);
      b32 = 32'h40400000;
      chk("busy_during_op", 32'(busy32), 32'h1);
      @(negedge clk);
    end
    start32 = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    // Reset in DIVIDE aborts with zeroed outputs and no DONE.
    issue32(32'h3F800000, 32'h40400000, 32'h0, 2'b00, -1, 1'b0, wd);
    repeat (10) @(negedge clk);
    nd = n_done32;
    rst_n = 1'b0;
    #1;
    chk("abort_res", q32o, 32'h0);
    chk("abort_exc", 32'(exc32), 32'h0);
    chk("abort_done", 32'(done32), 32'h0);
    chk("abort_busy", 32'(busy32), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", 32'(n_done32 - nd), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
